// File: rtl/bsg_piso_reset_width_p222_pkg.sv
// -----------------------------------------------------------------------------
// bsg_piso_reset_width_p222_pkg
// Shared definitions for the 222-bit parallel-in/serial-out drain stage.
//   piso_state_e    : two-state handshake FSM encoding (IDLE accepts, SEND emits)
//   calcNumCh       : number of output chunks needed to cover a word
//   calcCountWidth  : width of the chunk counter, never narrower than one bit
// -----------------------------------------------------------------------------
package bsg_piso_reset_width_p222_pkg;

   // IDLE waits for a word on the valid/ready side; SEND walks the held
   // word out one chunk at a time on the valid/yumi side.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } piso_state_e;

   // Ceiling division: a partial top chunk still needs its own slot, and it
   // goes out zero-padded above the real word bits.
   function automatic int calcNumCh(input int width, input int chunk);
      return (width + chunk - 1) / chunk;
   endfunction

   // A single-chunk build still gets a one-bit counter so the register and
   // the chunk index always have a legal, non-zero width.
   function automatic int calcCountWidth(input int numCh);
      if (numCh > 1) begin
         return $clog2(numCh);
      end
      return 1;
   endfunction

endpackage

// File: rtl/bsg_piso_reset_width_p222_dff.sv
// -----------------------------------------------------------------------------
// bsg_piso_reset_width_p222_dff
// Reset + enable register used to hold the captured parallel word.
//   clk_i    in   clock, updates on posedge
//   reset_i  in   synchronous active-high reset, clears the register to zero
//   en_i     in   load enable
//   data_i   in   WIDTH_P-bit value to load
//   data_o   out  WIDTH_P-bit registered value
// -----------------------------------------------------------------------------
module bsg_piso_reset_width_p222_dff #(
   parameter int WIDTH_P = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic [WIDTH_P-1:0] data_i,
   output logic [WIDTH_P-1:0] data_o
);

   logic [WIDTH_P-1:0] data_q;

   // Reset wins over enable so a word loaded in the same cycle as reset is
   // discarded, and otherwise the value only changes when explicitly loaded.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= data_i;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/bsg_piso_reset_width_p222.sv
// -----------------------------------------------------------------------------
// bsg_piso_reset_width_p222
// Parallel-in/serial-out drain stage. Accepts one WIDTH_P-bit word on a
// valid/ready handshake while idle, then emits it as CHUNK_P-bit chunks,
// least-significant chunk first, on a valid/yumi handshake. Holds one word.
//   clk_i    in   clock, all state updates on posedge
//   reset_i  in   synchronous active-high reset
//   v_i      in   input word valid
//   data_i   in   WIDTH_P-bit input word
//   ready_o  out  stage can accept a word this cycle
//   v_o      out  output chunk valid
//   data_o   out  CHUNK_P-bit current chunk (top chunk zero-padded)
//   yumi_i   in   consumer takes data_o this cycle
// -----------------------------------------------------------------------------
module bsg_piso_reset_width_p222
   import bsg_piso_reset_width_p222_pkg::*;
#(
   parameter int WIDTH_P = 222,
   parameter int CHUNK_P = 64
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [WIDTH_P-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [CHUNK_P-1:0] data_o,
   input  logic               yumi_i
);

   localparam int NUM_CH   = calcNumCh(WIDTH_P, CHUNK_P);
   localparam int CNT_W    = calcCountWidth(NUM_CH);
   localparam int PAD_W    = NUM_CH * CHUNK_P;
   localparam int LAST_CNT = NUM_CH - 1;

   piso_state_e        state_q;
   piso_state_e        state_d;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic [WIDTH_P-1:0] heldWord_q;
   logic [PAD_W-1:0]   paddedWord;
   logic [CHUNK_P-1:0] chunkArr [NUM_CH];
   logic               accept;

   // The handshake outputs come only from the registered state, so a
   // consumer never sees a combinational loop through v_i or yumi_i. They
   // are forced low while reset is held so nothing leaks out of a stage
   // that is about to be cleared.
   assign ready_o = ~reset_i & (state_q == IDLE);
   assign v_o     = ~reset_i & (state_q == SEND);
   assign accept  = v_i & ready_o;

   // The held word is loaded exactly once per transaction, on the accepting
   // handshake; v_i during SEND cannot reach the enable because ready_o is low.
   bsg_piso_reset_width_p222_dff #(
      .WIDTH_P (WIDTH_P)
   ) heldWordReg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (accept),
      .data_i  (data_i),
      .data_o  (heldWord_q)
   );

   // Widen the held word to a whole number of chunks so the top chunk can be
   // sliced like the others, with zeros filling the bits above the word.
   always_comb begin
      paddedWord                = '0;
      paddedWord[WIDTH_P-1:0]   = heldWord_q;
   end

   // Split the padded word into a fixed table of chunks with constant slice
   // positions, so selecting the current chunk is a plain mux on the counter.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_chunk
      assign chunkArr[i] = paddedWord[i*CHUNK_P +: CHUNK_P];
   end

   // Only drive a real chunk while it is valid; an idle or resetting stage
   // shows zeros so stale data is never mistaken for a fresh chunk.
   always_comb begin
      data_o = '0;
      if (v_o) begin
         data_o = chunkArr[count_q];
      end
   end

   // Next-state logic. IDLE waits for an accepted word and always starts the
   // walk at chunk zero. SEND advances one chunk per yumi_i and returns to
   // IDLE after the last chunk is taken; without yumi_i everything holds, so
   // backpressure can last indefinitely. A yumi_i seen in IDLE is ignored.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SEND;
               count_d = '0;
            end
         end
         SEND: begin
            if (yumi_i) begin
               if (count_q == CNT_W'(LAST_CNT)) begin
                  state_d = IDLE;
                  count_d = '0;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   // State and chunk counter registers. A reset in the middle of SEND drops
   // the word on the floor and the stage comes back up idle at chunk zero.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_bsg_piso_reset_width_p222.sv
// -----------------------------------------------------------------------------
// tb_bsg_piso_reset_width_p222
// Drives three builds of the drain stage (64-, 222- and 1-bit chunks) with a
// shared stimulus stream and compares each against a queue-of-chunks model.
// -----------------------------------------------------------------------------
module tb_bsg_piso_reset_width_p222;

   localparam int W = 222;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetIn;
   logic          vIn;
   logic          yumiIn;
   logic [W-1:0]  dataIn;

   logic          ready0, v0;
   logic [63:0]   data0;
   logic          ready1, v1;
   logic [221:0]  data1;
   logic          ready2, v2;
   logic [0:0]    data2;

   // One queue per build holding the chunks that build still owes the consumer.
   logic [W-1:0]  expQ [3][$];
   int            chunkWidth [3] = '{64, 222, 1};

   int compareCount  = 0;
   int mismatchCount = 0;
   int cycleCount    = 0;
   int spuriousYumi  = 0;
   int acceptLog [$];

   bsg_piso_reset_width_p222 #(.WIDTH_P(222), .CHUNK_P(64)) dut64 (
      .clk_i(clk), .reset_i(resetIn), .v_i(vIn), .data_i(dataIn),
      .ready_o(ready0), .v_o(v0), .data_o(data0), .yumi_i(yumiIn));

   bsg_piso_reset_width_p222 #(.WIDTH_P(222), .CHUNK_P(222)) dutWide (
      .clk_i(clk), .reset_i(resetIn), .v_i(vIn), .data_i(dataIn),
      .ready_o(ready1), .v_o(v1), .data_o(data1), .yumi_i(yumiIn));

   bsg_piso_reset_width_p222 #(.WIDTH_P(222), .CHUNK_P(1)) dutNarrow (
      .clk_i(clk), .reset_i(resetIn), .v_i(vIn), .data_i(dataIn),
      .ready_o(ready2), .v_o(v2), .data_o(data2), .yumi_i(yumiIn));

   // Count every comparison and report any disagreement.
   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic int numChunks(input int c);
      return (W + c - 1) / c;
   endfunction

   // Chunk k of a word: shift it down and keep c bits; bits past the word are zero.
   function automatic logic [W-1:0] sliceOf(input logic [W-1:0] w, input int k, input int c);
      logic [W-1:0] m;
      m = (c >= W) ? {W{1'b1}} : ((W'(1) << c) - W'(1));
      return (w >> (k * c)) & m;
   endfunction

   function automatic logic [W-1:0] randWord();
      logic [223:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   task automatic getOutputs(input int d, output logic r, output logic v,
                             output logic [W-1:0] data);
      case (d)
         0:       begin r = ready0; v = v0; data = W'(data0); end
         1:       begin r = ready1; v = v1; data = data1;     end
         default: begin r = ready2; v = v2; data = W'(data2); end
      endcase
   endtask

   // Drive one cycle of inputs, check all builds against the model, clock,
   // then advance the model by the handshakes that took place on that edge.
   task automatic applyStimulus(input logic rst, input logic v,
                                input logic [W-1:0] data, input logic yumi);
      logic         r;
      logic         vv;
      logic [W-1:0] dd;
      logic         expV;
      logic         expR;
      resetIn = rst;
      vIn     = v;
      dataIn  = data;
      yumiIn  = yumi;
      #1;
      for (int d = 0; d < 3; d++) begin
         getOutputs(d, r, vv, dd);
         expV = !rst && (expQ[d].size() != 0);
         expR = !rst && (expQ[d].size() == 0);
         checkOutput($sformatf("ready%0d@%0d", d, cycleCount), W'(r), W'(expR));
         checkOutput($sformatf("valid%0d@%0d", d, cycleCount), W'(vv), W'(expV));
         if (rst) begin
            checkOutput($sformatf("dataRst%0d@%0d", d, cycleCount), dd, '0);
         end else if (expV) begin
            checkOutput($sformatf("data%0d@%0d", d, cycleCount), dd, expQ[d][0]);
         end
      end
      if (!rst && yumi && expQ[0].size() == 0) spuriousYumi++;
      if (!rst && v && expQ[0].size() == 0) acceptLog.push_back(cycleCount);
      @(posedge clk);
      cycleCount++;
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            expQ[d].delete();
         end else if (expQ[d].size() != 0) begin
            if (yumi) void'(expQ[d].pop_front());
         end else if (v) begin
            for (int k = 0; k < numChunks(chunkWidth[d]); k++) begin
               expQ[d].push_back(sliceOf(data, k, chunkWidth[d]));
            end
         end
      end
      #1;
   endtask

   // Let the 64-bit build finish whatever it holds without offering new words.
   task automatic drainMain();
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, randWord(), 1'b1);
   endtask

   initial begin
      logic [W-1:0] one;
      int           bitList [8] = '{0, 63, 64, 127, 128, 191, 192, 221};
      one = W'(1);

      // Reset, then idle with spurious yumi and wandering data.
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, randWord(), 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, randWord(), 1'b1);

      // Single-bit words walked across chunk boundaries; v_i stays high with
      // junk during SEND so any illegal capture would show up.
      foreach (bitList[i]) begin
         applyStimulus(1'b0, 1'b1, one << bitList[i], 1'b0);
         for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, randWord(), 1'b1);
         drainMain();
      end

      // All-ones word exposes the zero padding of the top chunk.
      applyStimulus(1'b0, 1'b1, {W{1'b1}}, 1'b0);
      drainMain();

      // Backpressure in the middle of a word.
      applyStimulus(1'b0, 1'b1, randWord(), 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, randWord(), 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, randWord(), 1'b0);
      drainMain();

      // Back-to-back words with v_i and yumi_i held high.
      acceptLog.delete();
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, randWord(), 1'b1);
      checkOutput("b2bAccepts", W'(acceptLog.size()), W'(3));
      for (int i = 1; i < acceptLog.size(); i++) begin
         checkOutput($sformatf("b2bSpacing%0d", i),
                     W'(acceptLog[i] - acceptLog[i-1]), W'(5));
      end
      drainMain();

      // Reset while chunk 2 is on the output, then a fresh word.
      applyStimulus(1'b0, 1'b1, randWord(), 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, randWord(), 1'b1);
      applyStimulus(1'b1, 1'b0, randWord(), 1'b0);
      applyStimulus(1'b0, 1'b1, randWord(), 1'b0);
      drainMain();

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 40,
                       randWord(), $urandom_range(0, 99) < 60);
      end

      // Drain the narrow build so its last word is fully checked.
      for (int i = 0; i < 240; i++) applyStimulus(1'b0, 1'b0, randWord(), 1'b1);

      $display("[TB] note: %0d yumi_i pulses offered to an idle 64-bit stage were ignored",
               spuriousYumi);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
